ta_scan_ctrl: RTL and testbench
===============================

# ta_scan_ctrl

Sequencing controller for the TA-state read stage: on a start request it walks every (clause, LA-chunk) address pair of the TA state memory, clause-major, presenting one address per accepted beat to the memory-read stage. Advancement is gated by a downstream ready/valid handshake, so the compare stage can back-pressure the scan. It replaces free-running counter control with a start/done-framed, abortable scan and derives the legacy `stop_flag` for stages still using it.

## Interface
Parameters:
- `CLAUSES`, 2000: number of clauses; legal range 1..2^CNT_W.
- `LA_CHUNKS`, 49: LA chunks per clause; legal range 1..2^CNT_W.
- `CNT_W`, 17: width of both index outputs.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_flag_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin scan; sampled only in IDLE.
- `abort`  in  1  synchronous abort; any state returns to IDLE.
- `ds_ready`  in  1  read stage accepts the current address this cycle.
- `addr_valid`  out  1  `clause_idx`/`chunk_idx` hold a valid address.
- `clause_idx`  out  CNT_W  current clause address.
- `chunk_idx`  out  CNT_W  current LA-chunk offset.
- `first_chunk`  out  1  `addr_valid` and `chunk_idx == 0`.
- `last_chunk`  out  1  `addr_valid` and `chunk_idx == LA_CHUNKS-1`.
- `stop_flag`  out  1  combinational `!(addr_valid & ds_ready)`; legacy hold control.
- `busy`  out  1  high in SCAN.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: `addr_valid=0`, indices 0. `start=1` and `abort=0` -> SCAN, indices 0/0, `addr_valid=1`.
- SCAN: beat accepted when `addr_valid & ds_ready`. On accept:
  - `chunk_idx < LA_CHUNKS-1`: `chunk_idx+1`.
  - else `chunk_idx` <- 0 and `clause_idx+1`.
  - accept at (`CLAUSES-1`, `LA_CHUNKS-1`) -> DONE, `addr_valid` <- 0, indices <- 0.
  - no accept: all outputs held stable (valid must not drop, address must not change).
- DONE: `done=1` for exactly one cycle -> IDLE.
- `start` outside IDLE ignored; no queuing.
- `abort=1` in any state: next cycle IDLE, `addr_valid=0`, indices 0, `done` not asserted; abort wins over start and over a simultaneous final accept.
- Index arithmetic unsigned CNT_W bits; compare against `CLAUSES-1`/`LA_CHUNKS-1` truncated to CNT_W; no wrap past last pair.
- `CLAUSES=1`, `LA_CHUNKS=1`: single beat, then DONE.

## Timing
- Reset (async assert, sync release): state IDLE; `addr_valid`, `clause_idx`, `chunk_idx`, `first_chunk`, `last_chunk`, `busy`, `done` = 0; `stop_flag` = 1.
- `start` at cycle N -> `addr_valid`/`busy` high at N+1.
- Full scan with `ds_ready` held high: CLAUSES*LA_CHUNKS SCAN cycles, `done` in the following cycle, IDLE after; next `start` accepted in that IDLE cycle (min 2 cycles start-to-start overhead).
- Each stalled cycle adds exactly one cycle to the scan.
- All outputs except `stop_flag`, `first_chunk`, `last_chunk` registered; those three decode registers (plus `ds_ready` for `stop_flag`).
- Reset asserted mid-scan: immediate return to reset values.

## Configuration
- `TA_SCAN_PERF_EN` defined: adds output `stall_cycles` (32 bit), cleared when a scan starts, +1 each SCAN cycle with `addr_valid & !ds_ready`, saturating at 2^32-1, held after DONE/abort until next start; reset 0.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- CLAUSES=3, LA_CHUNKS=2, `ds_ready`=1, pulse `start` -> addresses (0,0),(0,1),(1,0),(1,1),(2,0),(2,1) on 6 consecutive cycles, `last_chunk` on odd beats, `done` 1 cycle later.
- Same config, `ds_ready` low for 3 cycles at (1,0) -> address and `addr_valid` held, `stop_flag`=1 for those cycles, `done` 3 cycles later; with PERF_EN `stall_cycles`=3.
- `abort` at (1,1) -> IDLE next cycle, `addr_valid`=0, no `done`; new `start` restarts at (0,0).
- `start` pulsed during SCAN -> ignored, single `done` only; `start`+`abort` together in IDLE -> stays IDLE.
- CLAUSES=1, LA_CHUNKS=1 -> one beat with `first_chunk`=`last_chunk`=1, `done` next cycle.
- Drop `rst_flag_n` mid-scan -> all outputs zero asynchronously, `stop_flag`=1.

Source files
------------

// File: rtl/ta_scan_ctrl.sv
// Clause-major (clause, LA-chunk) address scan for the TA-state read stage, start/done framed and abortable.
// Optional TA_SCAN_PERF_EN adds a saturating 32-bit stall counter output.
module ta_scan_ctrl #(
  parameter int CLAUSES   = 2000,
  parameter int LA_CHUNKS = 49,
  parameter int CNT_W     = 17
) (
  input  logic             clk,
  input  logic             rst_flag_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ds_ready,
  output logic             addr_valid,
  output logic [CNT_W-1:0] clause_idx,
  output logic [CNT_W-1:0] chunk_idx,
  output logic             first_chunk,
  output logic             last_chunk,
  output logic             stop_flag,
  output logic             busy,
  output logic             done
`ifdef TA_SCAN_PERF_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] LAST_CLAUSE = CNT_W'(CLAUSES - 1);
  localparam logic [CNT_W-1:0] LAST_CHUNK  = CNT_W'(LA_CHUNKS - 1);
  localparam logic [CNT_W-1:0] IDX_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] IDX_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [CNT_W-1:0] r_clause;
  logic [CNT_W-1:0] w_clause_nxt;
  logic [CNT_W-1:0] r_chunk;
  logic [CNT_W-1:0] w_chunk_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_accept;
  logic             w_chunk_last;
  logic             w_clause_last;

  assign w_accept      = r_valid & ds_ready;
  assign w_chunk_last  = (r_chunk == LAST_CHUNK);
  assign w_clause_last = (r_clause == LAST_CLAUSE);

  // Next-state and next-output decode; abort overrides every other transition.
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_valid;
    w_clause_nxt = r_clause;
    w_chunk_nxt  = r_chunk;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    if (abort) begin
      w_state_nxt  = ST_IDLE;
      w_valid_nxt  = 1'b0;
      w_clause_nxt = IDX_ZERO;
      w_chunk_nxt  = IDX_ZERO;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_clause_nxt = IDX_ZERO;
          w_chunk_nxt  = IDX_ZERO;
          if (start) begin
            w_state_nxt = ST_SCAN;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
          end
        end
        ST_SCAN: begin
          if (w_accept && w_chunk_last && w_clause_last) begin
            w_state_nxt  = ST_DONE;
            w_valid_nxt  = 1'b0;
            w_clause_nxt = IDX_ZERO;
            w_chunk_nxt  = IDX_ZERO;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b1;
          end else if (w_accept && w_chunk_last) begin
            w_chunk_nxt  = IDX_ZERO;
            w_clause_nxt = r_clause + IDX_ONE;
          end else if (w_accept) begin
            w_chunk_nxt  = r_chunk + IDX_ONE;
          end else begin
            // Stalled: address and valid must stay put until the read stage takes them.
            w_chunk_nxt  = r_chunk;
            w_clause_nxt = r_clause;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_valid_nxt  = 1'b0;
          w_clause_nxt = IDX_ZERO;
          w_chunk_nxt  = IDX_ZERO;
          w_busy_nxt   = 1'b0;
        end
      endcase
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_flag_n) begin
    if (!rst_flag_n) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_clause <= IDX_ZERO;
      r_chunk  <= IDX_ZERO;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_valid_nxt;
      r_clause <= w_clause_nxt;
      r_chunk  <= w_chunk_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign addr_valid  = r_valid;
  assign clause_idx  = r_clause;
  assign chunk_idx   = r_chunk;
  assign busy        = r_busy;
  assign done        = r_done;
  assign first_chunk = r_valid & (r_chunk == IDX_ZERO);
  assign last_chunk  = r_valid & w_chunk_last;
  assign stop_flag   = ~(r_valid & ds_ready);

`ifdef TA_SCAN_PERF_EN
  logic [31:0] r_stall;
  logic        w_scan_start;

  assign w_scan_start = (r_state == ST_IDLE) & start & ~abort;

  // Stall counter: cleared on scan start, saturating, held between scans.
  always_ff @(posedge clk or negedge rst_flag_n) begin
    if (!rst_flag_n) begin
      r_stall <= 32'd0;
    end else if (w_scan_start) begin
      r_stall <= 32'd0;
    end else if ((r_state == ST_SCAN) && r_valid && !ds_ready && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end else begin
      r_stall <= r_stall;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_ta_scan_ctrl.sv
// Scoreboard bench for ta_scan_ctrl: a beat-number model predicts every cycle's outputs for a 3x2 and a 1x1 instance.
module tb_ta_scan_ctrl;

  localparam int W  = 17;
  localparam int CA = 3;
  localparam int LA = 2;
  localparam int CB = 1;
  localparam int LB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, abort_a, ready_a, start_b, abort_b, ready_b;
  logic va, first_a, last_a, stop_a, busy_a, done_a;
  logic vb, first_b, last_b, stop_b, busy_b, done_b;
  logic [W-1:0] clause_a, chunk_a, clause_b, chunk_b;
`ifdef TA_SCAN_PERF_EN
  logic [31:0] stall_a, stall_b;
`endif

  ta_scan_ctrl #(.CLAUSES(CA), .LA_CHUNKS(LA), .CNT_W(W)) dut_a (
    .clk(clk), .rst_flag_n(rst_n), .start(start_a), .abort(abort_a), .ds_ready(ready_a),
    .addr_valid(va), .clause_idx(clause_a), .chunk_idx(chunk_a), .first_chunk(first_a),
    .last_chunk(last_a), .stop_flag(stop_a), .busy(busy_a), .done(done_a)
`ifdef TA_SCAN_PERF_EN
    , .stall_cycles(stall_a)
`endif
  );

  ta_scan_ctrl #(.CLAUSES(CB), .LA_CHUNKS(LB), .CNT_W(W)) dut_b (
    .clk(clk), .rst_flag_n(rst_n), .start(start_b), .abort(abort_b), .ds_ready(ready_b),
    .addr_valid(vb), .clause_idx(clause_b), .chunk_idx(chunk_b), .first_chunk(first_b),
    .last_chunk(last_b), .stop_flag(stop_b), .busy(busy_b), .done(done_b)
`ifdef TA_SCAN_PERF_EN
    , .stall_cycles(stall_b)
`endif
  );

  typedef struct packed {
    logic         valid;
    logic [W-1:0] clause;
    logic [W-1:0] chunk;
    logic         first;
    logic         last;
    logic         stop;
    logic         busy;
    logic         done;
`ifdef TA_SCAN_PERF_EN
    logic [31:0]  stall;
`endif
  } rec_t;

  // Model: a scan is just "beat n of C*L"; clause/chunk follow from division.
  typedef struct {
    bit     scan;
    int     n;
    bit     donep;
    longint stall;
  } mdl_t;

  mdl_t ma, mb;
  rec_t q_a[$];
  rec_t q_b[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic rec_t exp_out(mdl_t m, int l, bit ready, bit rstn);
    rec_t e;
    e = '0;
    e.stop = 1'b1;
    if (!rstn) return e;
`ifdef TA_SCAN_PERF_EN
    e.stall = 32'(m.stall);
`endif
    e.done = m.donep;
    if (m.scan) begin
      e.valid  = 1'b1;
      e.busy   = 1'b1;
      e.clause = W'(m.n / l);
      e.chunk  = W'(m.n % l);
      e.first  = ((m.n % l) == 0);
      e.last   = ((m.n % l) == l - 1);
      e.stop   = !ready;
    end
    return e;
  endfunction

  function automatic mdl_t step(mdl_t m, int c, int l, bit st, bit ab, bit ready, bit rstn);
    mdl_t nx;
    nx = m;
    if (!rstn) begin
      nx.scan = 1'b0; nx.n = 0; nx.donep = 1'b0; nx.stall = 0;
      return nx;
    end
    if (m.scan && !ready && m.stall < 64'h0000_0000_FFFF_FFFF) nx.stall = m.stall + 1;
    if (ab) begin
      nx.scan = 1'b0; nx.donep = 1'b0;
    end else if (m.donep) begin
      nx.donep = 1'b0;
    end else if (!m.scan) begin
      if (st) begin
        nx.scan = 1'b1; nx.n = 0; nx.stall = 0;
      end
    end else if (ready) begin
      if (m.n == c * l - 1) begin
        nx.scan = 1'b0; nx.donep = 1'b1;
      end else begin
        nx.n = m.n + 1;
      end
    end
    return nx;
  endfunction

  // One clock of stimulus: drive inputs, queue this cycle's expected outputs, advance the models.
  task automatic tick(bit sa, bit aa, bit ra, bit sb, bit ab, bit rb, bit rn);
    @(posedge clk);
    #1;
    start_a = sa; abort_a = aa; ready_a = ra;
    start_b = sb; abort_b = ab; ready_b = rb;
    rst_n   = rn;
    q_a.push_back(exp_out(ma, LA, ra, rn));
    q_b.push_back(exp_out(mb, LB, rb, rn));
    ma = step(ma, CA, LA, sa, aa, ra, rn);
    mb = step(mb, CB, LB, sb, ab, rb, rn);
  endtask

  task automatic ta(bit sa, bit aa, bit ra);
    tick(sa, aa, ra, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic cmp(string nm, rec_t e, rec_t g);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got v=%0b cl=%0d ch=%0d f=%0b l=%0b stop=%0b busy=%0b done=%0b (raw %h), want v=%0b cl=%0d ch=%0d f=%0b l=%0b stop=%0b busy=%0b done=%0b (raw %h)",
               nm, $time, g.valid, g.clause, g.chunk, g.first, g.last, g.stop, g.busy, g.done, g,
               e.valid, e.clause, e.chunk, e.first, e.last, e.stop, e.busy, e.done, e);
    end
  endtask

  rec_t mon_e, mon_g;

  // Monitor: compare DUT outputs each mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      mon_e = q_a.pop_front();
      mon_g = '0;
      mon_g.valid = va; mon_g.clause = clause_a; mon_g.chunk = chunk_a; mon_g.first = first_a;
      mon_g.last = last_a; mon_g.stop = stop_a; mon_g.busy = busy_a; mon_g.done = done_a;
`ifdef TA_SCAN_PERF_EN
      mon_g.stall = stall_a;
`endif
      cmp("dut_a_3x2", mon_e, mon_g);
    end
    if (q_b.size() > 0) begin
      mon_e = q_b.pop_front();
      mon_g = '0;
      mon_g.valid = vb; mon_g.clause = clause_b; mon_g.chunk = chunk_b; mon_g.first = first_b;
      mon_g.last = last_b; mon_g.stop = stop_b; mon_g.busy = busy_b; mon_g.done = done_b;
`ifdef TA_SCAN_PERF_EN
      mon_g.stall = stall_b;
`endif
      cmp("dut_b_1x1", mon_e, mon_g);
    end
  end

  initial begin
    ma = '{scan: 1'b0, n: 0, donep: 1'b0, stall: 0};
    mb = '{scan: 1'b0, n: 0, donep: 1'b0, stall: 0};
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;

    // Reset values, then idle.
    repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Full scan on both instances with ready held high.
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (8) ta(1'b0, 1'b0, 1'b1);

    // Three stalled cycles at (1,0).
    ta(1'b1, 1'b0, 1'b1);
    repeat (2) ta(1'b0, 1'b0, 1'b1);
    repeat (3) ta(1'b0, 1'b0, 1'b0);
    repeat (6) ta(1'b0, 1'b0, 1'b1);

    // Abort at (1,1), then restart from (0,0).
    ta(1'b1, 1'b0, 1'b1);
    repeat (3) ta(1'b0, 1'b0, 1'b1);
    ta(1'b0, 1'b1, 1'b1);
    ta(1'b0, 1'b0, 1'b1);
    ta(1'b1, 1'b0, 1'b1);
    repeat (9) ta(1'b0, 1'b0, 1'b1);

    // Start pulsed mid-scan and during the done cycle is ignored.
    ta(1'b1, 1'b0, 1'b1);
    ta(1'b0, 1'b0, 1'b1);
    ta(1'b1, 1'b0, 1'b1);
    repeat (4) ta(1'b0, 1'b0, 1'b1);
    ta(1'b1, 1'b0, 1'b1);
    repeat (3) ta(1'b0, 1'b0, 1'b1);

    // Start together with abort in idle stays idle.
    ta(1'b1, 1'b1, 1'b1);
    repeat (2) ta(1'b0, 1'b0, 1'b1);

    // Abort coincident with the final accept suppresses done.
    ta(1'b1, 1'b0, 1'b1);
    repeat (5) ta(1'b0, 1'b0, 1'b1);
    ta(1'b0, 1'b1, 1'b1);
    repeat (2) ta(1'b0, 1'b0, 1'b1);

    // Reset dropped mid-scan on both instances.
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 799) != 0));
    end

    repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
